key_schedule_ctrl: RTL and testbench
====================================

// Module: key_schedule_ctrl
// PURPOSE
//   DES key-schedule sequencer placed directly upstream of key_round.
//   Accepts a 64-bit key, applies PC-1 and drives one key_round instance
//   for 16 iterations, storing each 48-bit round key in a 16x48 buffer.
//   It then streams the keys to the cipher datapath over a valid/ready
//   handshake: K1..K16 when encrypting, K16..K1 when decrypting.
// PARAMETERS
//   NUM_ROUNDS  16  rounds generated and served; fixed at 16, no other value supported
// PORTS
//   i_clk        in   1   system clock, all state on rising edge
//   i_rst_n      in   1   asynchronous active-low reset
//   i_key_dv     in   1   key valid; accepted only when o_key_ready=1
//   i_key        in   64  DES key, i_key[63] = DES bit 1, parity bits ignored
//   i_decrypt    in   1   sampled with the key: 1 = serve keys in reverse order
//   o_key_ready  out  1   high only in IDLE
//   o_busy       out  1   high in GEN and SERVE
//   o_rk_dv      out  1   round key valid
//   i_rk_rdy     in   1   consumer accepts o_rk when o_rk_dv & i_rk_rdy
//   o_rk         out  48  round key, o_rk[47] = PC-2 output bit 1
//   o_rk_idx     out  4   0-based round number of o_rk (0 = K1)
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, o_key_ready=1, o_busy=0,
//   o_rk_dv=0, o_rk=0, o_rk_idx=0, round counter=0.
//   Key buffer and key_round C/D registers are not reset.
//   o_rk is forced to 0 whenever o_rk_dv=0.
// - FSM states: IDLE -> GEN -> SERVE -> IDLE.
// - IDLE:
//   On an edge with i_key_dv=1, register c0/d0 = PC-1(i_key) and the
//   decrypt flag, set rnd=0, go to GEN.
//   PC-1 mapping: c0[27-j] = i_key[64-PC1[j]] for j=0..27,
//   d0[27-j] = i_key[64-PC1[28+j]], using the standard FIPS 46-3 table.
// - GEN: 16 cycles, rnd = 0..15, with key_round i_dv=1 on every cycle.
//   key_round i_c/i_d = c0/d0 when rnd=0, else key_round's o_c/o_d.
//   i_shift_indicator = 1 (single rotate) when rnd is 0, 1, 8 or 15,
//   else 0 (double rotate).
//   Each edge writes buf[rnd] <= key_round o_rd_key.
//   On the edge with rnd=15, go to SERVE and load the pointer with 0,
//   or with 15 if decrypting.
// - SERVE:
//   o_rk_dv=1, o_rk=buf[ptr], o_rk_idx=ptr.
//   o_rk and o_rk_idx hold stable while o_rk_dv=1 and i_rk_rdy=0.
//   Each transfer steps ptr by +1 (encrypt) or -1 (decrypt) and counts
//   it; ptr wrap is unreachable.
//   On the 16th transfer, go to IDLE; o_rk_dv is 0 on the next cycle.
// - Latency: key accepted at edge T gives first o_rk_dv=1 in the cycle
//   after edge T+16. With i_rk_rdy tied high, all 16 keys appear on 16
//   consecutive cycles and o_key_ready returns 1 after the last one.
// - i_key_dv outside IDLE is ignored; no queueing; in-flight keys are
//   never corrupted.
// - No abort other than reset. Reset mid-GEN or mid-SERVE drops the key
//   and returns to IDLE; o_rk_dv falls asynchronously.
// TESTING
// - Key 133457799BBCDFF1, encrypt -> c0=F0CCAAF, d0=556678F;
//   idx0 o_rk=1B02EFFC7072, idx1=79AED9DBC9E5, idx15=CB3D8B0E17F5.
// - Same key, i_decrypt=1, i_rk_rdy=1 -> idx 15..0 on 16 consecutive
//   cycles; first CB3D8B0E17F5, last 1B02EFFC7072.
// - Random i_rk_rdy stalls -> o_rk/o_rk_idx stable while stalled;
//   exactly 16 transfers, no duplicates; o_key_ready=1 after the last.
// - i_key_dv pulsed during GEN and SERVE with a different key -> ignored;
//   the first key's sequence is served unchanged.
// - i_rst_n low at GEN rnd=7 and again mid-SERVE -> o_rk_dv=0 and
//   o_key_ready=1 immediately; a new key then gives a correct K1..K16.
// - Key with all parity bits flipped -> identical round keys to the
//   unmodified key.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - DES key-schedule sequencer: PC-1, 16-round generation into a buffer, ordered round-key streaming
// key_round performs one C/D rotation and PC-2; the top sequences it and serves K1..K16 or K16..K1.

module key_round (
  input  logic        clk,
  input  logic        i_dv,
  input  logic        i_shift_indicator,
  input  logic [27:0] i_c,
  input  logic [27:0] i_d,
  output logic [27:0] o_c,
  output logic [27:0] o_d,
  output logic [47:0] o_rd_key
);

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [55:0] cd;

  // DES bit 1 is the MSB, so a left rotate moves the MSB into bit 0
  assign c_rot = i_shift_indicator ? {i_c[26:0], i_c[27]} : {i_c[25:0], i_c[27:26]};
  assign d_rot = i_shift_indicator ? {i_d[26:0], i_d[27]} : {i_d[25:0], i_d[27:26]};
  assign cd    = {c_rot, d_rot};

  always_comb begin
    o_rd_key = '0;
    for (int j = 0; j < 48; j++) begin
      o_rd_key[47-j] = cd[56-PC2[j]];
    end
  end

  always_ff @(posedge clk) begin
    if (i_dv) begin
      o_c <= c_rot;
      o_d <= d_rot;
    end
  end

endmodule

module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_key_dv,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  output logic        o_key_ready,
  output logic        o_busy,
  output logic        o_rk_dv,
  input  logic        i_rk_rdy,
  output logic [47:0] o_rk,
  output logic [3:0]  o_rk_idx
);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  typedef enum logic [1:0] {IDLE, GEN, SERVE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  rnd;
  logic [3:0]  ptr;
  logic        dec;
  logic [27:0] c0;
  logic [27:0] d0;
  logic [55:0] pc1_cd;
  logic [47:0] key_buf [NUM_ROUNDS];
  logic        accept;
  logic        xfer;
  logic        last_rnd;
  logic        kr_dv;
  logic        kr_shift;
  logic [27:0] kr_c_in;
  logic [27:0] kr_d_in;
  logic [27:0] kr_c_out;
  logic [27:0] kr_d_out;
  logic [47:0] kr_key;

  always_comb begin
    pc1_cd = '0;
    for (int j = 0; j < 56; j++) begin
      pc1_cd[55-j] = i_key[64-PC1[j]];
    end
  end

  assign accept   = (state == IDLE) && i_key_dv;
  assign xfer     = o_rk_dv && i_rk_rdy;
  assign last_rnd = (rnd == 4'd15);
  assign kr_shift = (rnd == 4'd0) || (rnd == 4'd1) || (rnd == 4'd8) || (rnd == 4'd15);
  assign kr_c_in  = (rnd == 4'd0) ? c0 : kr_c_out;
  assign kr_d_in  = (rnd == 4'd0) ? d0 : kr_d_out;

  key_round u_key_round (
    .clk               (i_clk),
    .i_dv              (kr_dv),
    .i_shift_indicator (kr_shift),
    .i_c               (kr_c_in),
    .i_d               (kr_d_in),
    .o_c               (kr_c_out),
    .o_d               (kr_d_out),
    .o_rd_key          (kr_key)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_key_dv)            state_nxt = GEN;
      GEN:     if (last_rnd)            state_nxt = SERVE;
      SERVE:   if (xfer && last_rnd)    state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_key_ready = (state == IDLE);
    o_busy      = (state == GEN) || (state == SERVE);
    o_rk_dv     = (state == SERVE);
    kr_dv       = (state == GEN);
    o_rk        = o_rk_dv ? key_buf[ptr] : 48'd0;
    o_rk_idx    = o_rk_dv ? ptr : 4'd0;
  end

  // rnd counts generation rounds in GEN, then completed transfers in SERVE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rnd <= '0;
      ptr <= '0;
      dec <= 1'b0;
    end else if (accept) begin
      rnd <= '0;
      dec <= i_decrypt;
    end else if (state == GEN) begin
      rnd <= rnd + 4'd1;
      if (last_rnd) ptr <= dec ? 4'd15 : 4'd0;
    end else if ((state == SERVE) && xfer) begin
      rnd <= rnd + 4'd1;
      ptr <= dec ? ptr - 4'd1 : ptr + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      c0 <= pc1_cd[55:28];
      d0 <= pc1_cd[27:0];
    end
    if (state == GEN) key_buf[rnd] <= kr_key;
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - randomized self-checking bench for key_schedule_ctrl against a bit-list DES key-schedule model
module tb_key_schedule_ctrl;

  localparam logic [63:0] KNOWN  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY = 64'h0101010101010101;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_dv = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        rk_rdy = 1'b0;
  logic        key_ready;
  logic        busy;
  logic        rk_dv;
  logic [47:0] rk;
  logic [3:0]  rk_idx;

  int n_cmp = 0;
  int n_bad = 0;

  key_schedule_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_dv    (key_dv),
    .i_key       (key),
    .i_decrypt   (decrypt),
    .o_key_ready (key_ready),
    .o_busy      (busy),
    .o_rk_dv     (rk_dv),
    .i_rk_rdy    (rk_rdy),
    .o_rk        (rk),
    .o_rk_idx    (rk_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Positions are DES-numbered (1-based, bit 1 = MSB); rotations done one place at a time
  function automatic logic [767:0] ref_keys(input logic [63:0] k);
    logic [767:0] out;
    bit           cd [57];
    bit           t;
    out = '0;
    for (int i = 1; i <= 56; i++) cd[i] = k[64-PC1_T[i-1]];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        t = cd[1];
        for (int i = 1; i < 28; i++) cd[i] = cd[i+1];
        cd[28] = t;
        t = cd[29];
        for (int i = 29; i < 56; i++) cd[i] = cd[i+1];
        cd[56] = t;
      end
      for (int j = 1; j <= 48; j++) out[r*48 + 48 - j] = cd[PC2_T[j-1]];
    end
    return out;
  endfunction

  task automatic run_key(input logic [63:0] k, input bit dec, input int stall_pct,
                         input bit noise, output logic [767:0] got);
    logic [767:0] exp;
    logic [47:0]  hrk;
    logic [3:0]   hidx;
    int           cyc, ntx, first, last, nidx;
    bit           held;
    exp = ref_keys(k);
    got = '0;
    cyc = 0; ntx = 0; first = -1; last = -1; held = 0; hrk = '0; hidx = '0;
    nidx = dec ? 15 : 0;
    @(negedge clk);
    check("ready_before", 64'(key_ready), 64'd1);
    key = k; decrypt = dec; key_dv = 1'b1;
    while (ntx < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check("hold_dv", 64'(rk_dv), 64'd1);
        check("hold_rk", 64'(rk), 64'(hrk));
        check("hold_idx", 64'(rk_idx), 64'(hidx));
      end
      rk_rdy = ($urandom_range(99) >= stall_pct);
      held = 0;
      if (rk_dv) begin
        if (first < 0) begin
          first = cyc;
          check("latency", 64'(cyc), 64'd17);
        end
        check("busy_serve", 64'(busy), 64'd1);
        check("idx", 64'(rk_idx), 64'(nidx));
        check("rk", 64'(rk), 64'(exp[nidx*48 +: 48]));
        if (rk_rdy) begin
          got[nidx*48 +: 48] = rk;
          ntx++;
          last = cyc;
          nidx = dec ? nidx - 1 : nidx + 1;
        end else begin
          held = 1;
          hrk  = rk;
          hidx = rk_idx;
        end
      end
      key_dv = noise && (ntx < 16) && ($urandom_range(1) == 1);
      if (key_dv) begin
        key = {$urandom, $urandom};
        decrypt = $urandom_range(1) == 1;
      end
    end
    key_dv = 1'b0;
    check("tx_count", 64'(ntx), 64'd16);
    if (stall_pct == 0) check("consecutive", 64'(last - first), 64'd15);
    @(negedge clk);
    check("dv_after", 64'(rk_dv), 64'd0);
    check("ready_after", 64'(key_ready), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("rk_zero", 64'(rk), 64'd0);
  endtask

  task automatic reset_during(input int wait_negs, input bit in_serve);
    @(negedge clk);
    key = {$urandom, $urandom}; decrypt = 1'b0; key_dv = 1'b1; rk_rdy = 1'b1;
    for (int i = 0; i < wait_negs; i++) begin
      @(negedge clk);
      key_dv = 1'b0;
    end
    if (in_serve) check("pre_rst_dv", 64'(rk_dv), 64'd1);
    else          check("pre_rst_gen", 64'(busy & ~rk_dv), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_dv", 64'(rk_dv), 64'd0);
    check("rst_ready", 64'(key_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rk", 64'(rk), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [767:0] got;
  logic [767:0] exp_known;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_known = ref_keys(KNOWN);
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(key_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_dv", 64'(rk_dv), 64'd0);
    check("reset_rk", 64'(rk), 64'd0);
    check("reset_idx", 64'(rk_idx), 64'd0);
    rst_n = 1'b1;

    run_key(KNOWN, 1'b0, 0, 1'b0, got);
    check("enc_k1", 64'(got[0 +: 48]), 64'h1B02EFFC7072);
    check("enc_k2", 64'(got[48 +: 48]), 64'h79AED9DBC9E5);
    check("enc_k16", 64'(got[720 +: 48]), 64'hCB3D8B0E17F5);

    run_key(KNOWN, 1'b1, 0, 1'b0, got);
    check("dec_k16", 64'(got[720 +: 48]), 64'hCB3D8B0E17F5);
    check("dec_k1", 64'(got[0 +: 48]), 64'h1B02EFFC7072);

    run_key(KNOWN, 1'b0, 50, 1'b1, got);
    check("noise_k1", 64'(got[0 +: 48]), 64'h1B02EFFC7072);
    check("noise_k16", 64'(got[720 +: 48]), 64'hCB3D8B0E17F5);

    for (int n = 0; n < 6; n++) begin
      run_key({$urandom, $urandom}, $urandom_range(1) == 1, $urandom_range(60), 1'b1, got);
    end

    run_key(KNOWN ^ PARITY, 1'b0, 30, 1'b0, got);
    for (int r = 0; r < 16; r++) check("parity_rk", 64'(got[r*48 +: 48]), 64'(exp_known[r*48 +: 48]));

    reset_during(8, 1'b0);
    reset_during(22, 1'b1);
    run_key(KNOWN, 1'b0, 25, 1'b0, got);
    check("post_rst_k1", 64'(got[0 +: 48]), 64'h1B02EFFC7072);
    check("post_rst_k16", 64'(got[720 +: 48]), 64'hCB3D8B0E17F5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
